// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file with reset clear sweep, read bypass and retire bookkeeping
module wb_regfile #(
    parameter int BYPASS   = 1,
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         wb_reg_wdata,
    input  logic                wb_wr_reg_en,
    input  logic [4:0]          wb_wr_reg_addr,
    input  logic [31:0]         wb_pc,
    input  logic [31:0]         wb_inst,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [31:0]         rs1_rdata,
    output logic [31:0]         rs2_rdata,
    output logic                init_busy,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic [31:0]         last_pc,
    output logic                wb_drop_err
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic BYP = (BYPASS != 0);

    state_t      state;
    state_t      state_next;
    logic [4:0]  sweep_idx;
    logic [4:0]  sweep_idx_next;

    // Entry 0 is never written nor read; x0 is produced by the read muxes.
    logic [31:0] regs [32];

    logic        arr_we;
    logic [4:0]  arr_waddr;
    logic [31:0] arr_wdata;

    // FSM state and sweep pointer; reset always restarts the sweep at x1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_idx <= 5'd1;
        end else begin
            state     <= state_next;
            sweep_idx <= sweep_idx_next;
        end
    end

    // Next state and the single array write port, shared between sweep and WB.
    always_comb begin
        state_next     = state;
        sweep_idx_next = sweep_idx;
        arr_we         = 1'b0;
        arr_waddr      = wb_wr_reg_addr;
        arr_wdata      = wb_reg_wdata;
        case (state)
            INIT: begin
                arr_we         = 1'b1;
                arr_waddr      = sweep_idx;
                arr_wdata      = 32'h0;
                sweep_idx_next = sweep_idx + 5'd1;
                if (sweep_idx == 5'd31) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                arr_we = wb_wr_reg_en && (wb_wr_reg_addr != 5'd0);
            end
            default: begin
                state_next = INIT;
            end
        endcase
        // Reset wins over any pending sweep or WB write.
        if (rst) begin
            arr_we = 1'b0;
        end
    end

    // Array storage without reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            regs[arr_waddr] <= arr_wdata;
        end
    end

    // Retire counter, last retired PC and the sticky dropped-write flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt  <= '0;
            last_pc     <= 32'h0;
            wb_drop_err <= 1'b0;
        end else if (state == INIT) begin
            if (wb_wr_reg_en) begin
                wb_drop_err <= 1'b1;
            end
        end else if (wb_inst != 32'h0) begin
            retire_cnt <= retire_cnt + RETIRE_W'(1);
            last_pc    <= wb_pc;
        end
    end

    // Read port 1: zero during sweep and for x0, optional same-cycle bypass.
    always_comb begin
        rs1_rdata = 32'h0;
        if (state == RUN && rs1_addr != 5'd0) begin
            if (BYP && wb_wr_reg_en && wb_wr_reg_addr == rs1_addr) begin
                rs1_rdata = wb_reg_wdata;
            end else begin
                rs1_rdata = regs[rs1_addr];
            end
        end
    end

    // Read port 2: same rules as port 1, bypassing independently.
    always_comb begin
        rs2_rdata = 32'h0;
        if (state == RUN && rs2_addr != 5'd0) begin
            if (BYP && wb_wr_reg_en && wb_wr_reg_addr == rs2_addr) begin
                rs2_rdata = wb_reg_wdata;
            end else begin
                rs2_rdata = regs[rs2_addr];
            end
        end
    end

    assign init_busy = (state == INIT);

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized and directed checks of wb_regfile against a behavioural model
module tb_wb_regfile;

    localparam int RW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [31:0]   wb_reg_wdata;
    logic          wb_wr_reg_en;
    logic [4:0]    wb_wr_reg_addr;
    logic [31:0]   wb_pc;
    logic [31:0]   wb_inst;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;

    logic [31:0]   rs1_b, rs2_b, pc_b;
    logic          busy_b, drop_b;
    logic [RW-1:0] cnt_b;
    logic [31:0]   rs1_n, rs2_n, pc_n;
    logic          busy_n, drop_n;
    logic [RW-1:0] cnt_n;

    wb_regfile #(.BYPASS(1), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_wdata(wb_reg_wdata), .wb_wr_reg_en(wb_wr_reg_en),
        .wb_wr_reg_addr(wb_wr_reg_addr), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_b), .rs2_rdata(rs2_b), .init_busy(busy_b),
        .retire_cnt(cnt_b), .last_pc(pc_b), .wb_drop_err(drop_b)
    );

    wb_regfile #(.BYPASS(0), .RETIRE_W(RW)) dut_nb (
        .clk(clk), .rst(rst),
        .wb_reg_wdata(wb_reg_wdata), .wb_wr_reg_en(wb_wr_reg_en),
        .wb_wr_reg_addr(wb_wr_reg_addr), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_n), .rs2_rdata(rs2_n), .init_busy(busy_n),
        .retire_cnt(cnt_n), .last_pc(pc_n), .wb_drop_err(drop_n)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model: architectural register values, remaining sweep cycles, retire state.
    logic [31:0]   m_regs [32];
    int            m_sweep = 31;
    logic [RW-1:0] m_cnt = '0;
    logic [31:0]   m_pc = 32'h0;
    bit            m_drop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (m_sweep > 0 || a == 5'd0) return 32'h0;
        if (byp && wb_wr_reg_en && wb_wr_reg_addr == a) return wb_reg_wdata;
        return m_regs[a];
    endfunction

    // Model update at each clock edge from the inputs present at that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_sweep = 31;
            m_cnt   = '0;
            m_pc    = 32'h0;
            m_drop  = 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else if (m_sweep > 0) begin
            m_sweep = m_sweep - 1;
            if (wb_wr_reg_en) m_drop = 1'b1;
        end else begin
            if (wb_wr_reg_en && wb_wr_reg_addr != 5'd0) m_regs[wb_wr_reg_addr] = wb_reg_wdata;
            if (wb_inst != 32'h0) begin
                m_cnt = m_cnt + 1'b1;
                m_pc  = wb_pc;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("b_rs1", rs1_b, exp_rd(rs1_addr, 1'b1));
            check("b_rs2", rs2_b, exp_rd(rs2_addr, 1'b1));
            check("n_rs1", rs1_n, exp_rd(rs1_addr, 1'b0));
            check("n_rs2", rs2_n, exp_rd(rs2_addr, 1'b0));
            check("b_busy", busy_b, m_sweep > 0);
            check("n_busy", busy_n, m_sweep > 0);
            check("b_cnt", cnt_b, m_cnt);
            check("n_cnt", cnt_n, m_cnt);
            check("b_last_pc", pc_b, m_pc);
            check("n_last_pc", pc_n, m_pc);
            check("b_drop", drop_b, m_drop);
            check("n_drop", drop_n, m_drop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy_b && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic idle();
        wb_wr_reg_en   = 1'b0;
        wb_wr_reg_addr = 5'd0;
        wb_reg_wdata   = 32'h0;
        wb_inst        = 32'h0;
        wb_pc          = 32'h0;
    endtask

    int n;
    logic [31:0] insts [4];

    initial begin
        insts[0] = 32'h0000_0013;
        insts[1] = 32'h0000_0000;
        insts[2] = 32'h00A1_2023;
        insts[3] = 32'h0000_0063;
        rst = 1'b1;
        idle();
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        step();
        chk_en = 1'b1;
        step();
        check("lit_busy_in_rst", busy_b, 1'b1);
        rst = 1'b0;

        // Initial sweep length and preload of x5.
        wait_sweep(n);
        check("lit_init_len", n, 31);
        wb_wr_reg_en = 1'b1; wb_wr_reg_addr = 5'd5; wb_reg_wdata = 32'hDEAD_BEEF;
        step();
        idle();
        rs1_addr = 5'd5;
        #1;
        check("lit_x5_preload", rs1_b, 32'hDEAD_BEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_sweep(n);
        check("lit_resweep_len", n, 31);
        check("lit_x5_cleared", rs1_b, 32'h0);
        check("lit_cnt_reset", cnt_b, 64'h0);

        // Write/read and x0 discard.
        wb_wr_reg_en = 1'b1; wb_wr_reg_addr = 5'd7; wb_reg_wdata = 32'h1234_5678;
        step();
        wb_wr_reg_addr = 5'd0; wb_reg_wdata = 32'hFFFF_FFFF;
        step();
        idle();
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1;
        check("lit_x7", rs1_b, 32'h1234_5678);
        check("lit_x0", rs2_b, 32'h0);

        // Bypass vs old value.
        wb_wr_reg_en = 1'b1; wb_wr_reg_addr = 5'd9; wb_reg_wdata = 32'h0000_0011;
        step();
        wb_reg_wdata = 32'hA5A5_0001;
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        #1;
        check("lit_byp_rs1", rs1_b, 32'hA5A5_0001);
        check("lit_byp_rs2", rs2_b, 32'hA5A5_0001);
        check("lit_nobyp_rs1", rs1_n, 32'h0000_0011);
        check("lit_nobyp_rs2", rs2_n, 32'h0000_0011);
        step();
        idle();

        // Retire sequence with one bubble.
        for (int i = 0; i < 4; i++) begin
            wb_inst = insts[i];
            wb_pc   = 32'h100 + 32'(4 * i);
            step();
        end
        idle();
        check("lit_retire_cnt", cnt_b, 64'd3);
        check("lit_last_pc", pc_b, 32'h10C);

        // Counter wrap.
        force dut.retire_cnt = {RW{1'b1}};
        force dut_nb.retire_cnt = {RW{1'b1}};
        m_cnt = {RW{1'b1}};
        #1;
        release dut.retire_cnt;
        release dut_nb.retire_cnt;
        wb_inst = 32'h0000_0013; wb_pc = 32'h200;
        step();
        idle();
        check("lit_wrap", cnt_b, 64'h0);

        // Writes during sweep and reset mid-sweep.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb_wr_reg_en = 1'b1; wb_wr_reg_addr = 5'd3; wb_reg_wdata = 32'hCAFE_F00D;
        repeat (10) step();
        check("lit_drop_set", drop_b, 1'b1);
        idle();
        rst = 1'b1;
        step();
        check("lit_drop_cleared", drop_b, 1'b0);
        rst = 1'b0;
        n = 0;
        while (busy_b && n < 40) begin
            wb_wr_reg_en = (n < 3); wb_wr_reg_addr = 5'd3; wb_reg_wdata = 32'hCAFE_F00D;
            step();
            n++;
        end
        idle();
        check("lit_restart_len", n, 31);
        rs1_addr = 5'd3;
        #1;
        check("lit_x3_dropped", rs1_b, 32'h0);
        check("lit_drop_sticky", drop_b, 1'b1);
        repeat (5) step();
        check("lit_drop_still", drop_b, 1'b1);

        // Randomized traffic, including occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            wb_wr_reg_en   = $urandom_range(0, 1);
            wb_wr_reg_addr = 5'($urandom_range(0, 31));
            wb_reg_wdata   = $urandom;
            wb_pc          = $urandom;
            wb_inst        = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            rs1_addr       = ($urandom_range(0, 3) == 0) ? wb_wr_reg_addr : 5'($urandom_range(0, 31));
            rs2_addr       = ($urandom_range(0, 3) == 0) ? wb_wr_reg_addr : 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;
        idle();
        step();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
